// File: rtl/register_pkg.sv
// register_pkg
//   Shared constants and helpers for the elastic register chain.
//   DEFAULT_WORD_WIDTH / DEFAULT_DEPTH / DEFAULT_RESET_VALUE are the
//   parameter defaults of register_pipeline. occupancy_width() sizes the
//   optional occupancy counter so it can hold 0..depth.
package register_pkg;

  localparam int DEFAULT_WORD_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 2;
  localparam logic [DEFAULT_WORD_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

  function automatic int occupancy_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_stage.sv
// pipeline_stage
//   One data+valid register of the elastic chain.
//   Ports:
//     clock       rising-edge clock
//     areset      asynchronous active-high reset (valid=0, data=RESET_VALUE)
//     clear       synchronous clear, same end state as areset
//     load        stage is ready and the chain is enabled this edge
//     next_valid  valid bit offered by the upstream stage
//     next_data   data word offered by the upstream stage
//     valid       stage holds a word
//     data        stage data
//   The valid bit loads whenever load=1 (so a bubble can move in), while the
//   data register only loads when a real word arrives; its content while
//   valid=0 is don't-care and is simply left alone.
module pipeline_stage
  import register_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = WORD_WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  next_valid,
  input  logic [WORD_WIDTH-1:0] next_data,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] data
);

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= next_valid;
    end
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      data <= RESET_VALUE;
    end else if (clear) begin
      data <= RESET_VALUE;
    end else if (load && next_valid) begin
      data <= next_data;
    end
  end

endmodule

// File: rtl/register_pipeline.sv
// register_pipeline
//   Elastic register chain: DEPTH stages of WORD_WIDTH-bit words with a
//   valid/ready handshake at both ends. Empty stages (bubbles) collapse, so
//   a downstream stall fills the chain before it stops the input.
//   Ports:
//     clock         rising-edge clock
//     areset        asynchronous active-high reset
//     clock_enable  0 freezes all stages and blocks both handshakes
//     clear         synchronous clear of every stage, wins over transfers
//     in_valid/in_ready/in_data     upstream handshake and word
//     out_valid/out_ready/out_data  downstream handshake and word
//     occupancy     count of valid stages, present only when
//                   REGISTER_PIPELINE_OCCUPANCY_EN is defined
//
//   Handshake: a word moves across a port on a rising edge where valid and
//   ready are both 1 at that port. valid never depends on ready at the same
//   port; ready here is combinational from out_ready (the ready chain runs
//   straight through the stages). While valid=1 and ready=0 the sender holds
//   its word and keeps valid high. Both ready and valid are forced to 0
//   while clock_enable=0 or clear=1, so no transfer completes then.
module register_pipeline
  import register_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = WORD_WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  clock_enable,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
  ,
  output logic [occupancy_width(DEPTH)-1:0] occupancy
`endif
);

  // Chain advances only on an enabled, non-clearing edge.
  logic gate;
  assign gate = clock_enable && !clear;

  logic [DEPTH-1:0]      valid;
  logic [WORD_WIDTH-1:0] data     [DEPTH];
  logic [DEPTH-1:0]      up_valid;
  logic [WORD_WIDTH-1:0] up_data  [DEPTH];
  logic [DEPTH-1:0]      ready;

  // A stage is ready when it is empty or everything ahead of it moves.
  // Walk from the output back to the input so each stage sees the ready of
  // the stage after it.
  always_comb begin
    logic [DEPTH:0] chain;
    chain        = '0;
    chain[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain[i] = !valid[i] || chain[i+1];
    end
    ready = chain[DEPTH-1:0];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid;
      assign up_data[i]  = in_data;
    end else begin : g_body
      assign up_valid[i] = valid[i-1];
      assign up_data[i]  = data[i-1];
    end

    pipeline_stage #(
      .WORD_WIDTH  (WORD_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clock      (clock),
      .areset     (areset),
      .clear      (clear),
      .load       (gate && ready[i]),
      .next_valid (up_valid[i]),
      .next_data  (up_data[i]),
      .valid      (valid[i]),
      .data       (data[i])
    );
  end

  assign in_ready  = gate && ready[0];
  assign out_valid = gate && valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
  localparam int OCC_W = occupancy_width(DEPTH);

  logic in_fire;
  logic out_fire;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // in_ready/out_valid already include the gating, so a frozen or clearing
  // edge never counts as a transfer.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      occupancy <= '0;
    end else if (clear) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_register_pipeline.sv
// tb_register_pipeline
//   Self-checking bench for register_pipeline with DEPTH=3, WORD_WIDTH=8 and
//   a non-zero RESET_VALUE. A reference model keeps the words in flight as a
//   queue with their stage positions; a word moves forward when some stage
//   ahead of it is empty or the output is draining.
module tb_register_pipeline;

  localparam int W = 8;
  localparam int D = 3;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clock;
  logic         areset;
  logic         clock_enable;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
  logic [$clog2(D+1)-1:0] occupancy;
`endif

  register_pipeline #(
    .WORD_WIDTH  (W),
    .DEPTH       (D),
    .RESET_VALUE (RV)
  ) dut (
    .clock        (clock),
    .areset       (areset),
    .clock_enable (clock_enable),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    ,
    .occupancy    (occupancy)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           pos_q[$];
  logic         last_in_fire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    pos_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model (and optional explicit expectations), advance the
  // model at the rising edge, return at the next falling edge.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic ce, input logic clr, input bit use_exp,
                       input logic e_ir, input logic e_ov, input logic [W-1:0] e_od);
    logic m_gate, m_ir, m_ov;
    in_valid     = iv;
    in_data      = id;
    out_ready    = ordy;
    clock_enable = ce;
    clear        = clr;
    #1;
    m_gate = ce && !clr;
    m_ir   = m_gate && ((exp_q.size() < D) || ordy);
    m_ov   = m_gate && (pos_q.size() > 0) && (pos_q[0] == D - 1);
    chk("in_ready", in_ready, m_ir);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_data", out_data, exp_q[0]);
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    chk("occupancy", occupancy, exp_q.size());
`endif
    if (use_exp) begin
      chk("vec_in_ready", in_ready, e_ir);
      chk("vec_out_valid", out_valid, e_ov);
      if (e_ov) chk("vec_out_data", out_data, e_od);
    end
    @(posedge clock);
    last_in_fire = m_ir && iv;
    if (clr) begin
      model_flush();
    end else if (ce) begin
      for (int k = 0; k < pos_q.size(); k++) begin
        // Older words sit at higher positions, so the k older words fill
        // k of the D-1-p stages ahead of this one.
        if ((pos_q[k] < D - 1) && (((D - 1 - pos_q[k]) > k) || ordy)) pos_q[k]++;
      end
      if (m_ov && ordy) begin
        void'(exp_q.pop_front());
        void'(pos_q.pop_front());
      end
      if (last_in_fire) begin
        exp_q.push_back(id);
        pos_q.push_back(0);
      end
    end
    @(negedge clock);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ord;
    logic         ce;
    logic         clr;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [W-1:0] id, input logic ord,
                              input logic ce, input logic clr, input logic e_ir,
                              input logic e_ov, input logic [W-1:0] e_od);
    vec_t v;
    v.iv = iv; v.id = id; v.ord = ord; v.ce = ce; v.clr = clr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    vecs.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  logic         cur_iv;
  logic [W-1:0] cur_id;

  initial begin
    // backpressure: fill, stall input, drain in order
    add(1, 8'h11, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h22, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h33, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h44, 0, 1, 0, 0, 1, 8'h11);
    add(1, 8'h44, 1, 1, 0, 1, 1, 8'h11);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h22);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h33);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h44);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00);
    // bubble collapse: words on alternate cycles pack at the output end
    add(1, 8'h66, 0, 1, 0, 1, 0, 8'h00);
    add(0, 8'h00, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h77, 0, 1, 0, 1, 0, 8'h00);
    add(0, 8'h00, 0, 1, 0, 1, 1, 8'h66);
    add(0, 8'h00, 0, 1, 0, 1, 1, 8'h66);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h66);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h77);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00);
    // clear with a full chain and a pending input word
    add(1, 8'h81, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h82, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h83, 0, 1, 0, 1, 0, 8'h00);
    add(1, 8'h84, 0, 1, 1, 0, 0, 8'h00);
    add(1, 8'h84, 1, 1, 0, 1, 0, 8'h00);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h84);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00);
    // clock_enable low for 4 cycles mid-stream
    add(1, 8'h91, 1, 1, 0, 1, 0, 8'h00);
    add(1, 8'h92, 1, 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(1, 8'h93, 1, 0, 0, 0, 0, 8'h00);
    add(1, 8'h93, 1, 1, 0, 1, 0, 8'h00);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h91);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h92);
    add(0, 8'h00, 1, 1, 0, 1, 1, 8'h93);
    add(0, 8'h00, 1, 1, 0, 1, 0, 8'h00);

    // reset
    areset       = 1'b1;
    clock_enable = 1'b1;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    last_in_fire = 1'b0;
    model_flush();
    repeat (2) @(negedge clock);
    areset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, RV);
    chk("reset_in_ready", in_ready, 1'b1);

    // streaming 0x01..0x0A, 3-cycle latency, no gaps
    for (int c = 0; c < 14; c++) begin
      cycle((c < 10), W'(c + 1), 1'b1, 1'b1, 1'b0, 1'b1,
            1'b1, (c >= 3 && c < 13), W'(c - 2));
    end

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].iv, vecs[i].id, vecs[i].ord, vecs[i].ce, vecs[i].clr, 1'b1,
            vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od);
    end

    // asynchronous reset mid-stream with a full chain
    cycle(1, 8'hA1, 0, 1, 0, 1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1, 8'hA2, 0, 1, 0, 1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1, 8'hA3, 0, 1, 0, 1'b1, 1'b1, 1'b0, 8'h00);
    in_valid = 1'b0;
    #1;
    chk("pre_areset_out_valid", out_valid, 1'b1);
    #1;
    areset = 1'b1;
    #1;
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_out_data", out_data, RV);
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    chk("areset_occupancy", occupancy, 0);
`endif
    model_flush();
    @(posedge clock);
    @(negedge clock);
    areset = 1'b0;
    #1;
    chk("post_areset_in_ready", in_ready, 1'b1);

    // randomized traffic against the model
    cur_iv       = 1'b0;
    cur_id       = '0;
    last_in_fire = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!cur_iv || last_in_fire) begin
        cur_iv = ($urandom_range(0, 3) != 0);
        cur_id = W'($urandom_range(0, 255));
      end
      cycle(cur_iv, cur_id, ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 31) == 0), 1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int n = 0; n < D + 2; n++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
